pingpong_main_buff: RTL and testbench
=====================================

// Module: pingpong_main_buff
// PURPOSE
//  Parametrised, double-banked successor of the convolution input buffer. The loader writes LANES-element
//  words row-major into one bank while the convolution engine reads strided RD_LANES-element columns from
//  the other. Banks swap by handshake (wr_last / rd_release). Reads are registered, 1-cycle latency.
// PARAMETERS
//  DATA_W    8  element width (bits)
//  ROWS      8  rows per bank
//  COLS      8  columns per bank; COLS % LANES == 0
//  LANES     4  elements per write word
//  RD_LANES  4  elements per read column
//  RD_STRIDE 2  row step between read lanes; RD_LANES*RD_STRIDE == ROWS (elaboration error otherwise)
//  derived: WORDS=ROWS*COLS/LANES, WA_W=$clog2(WORDS), RA_W=$clog2(RD_STRIDE*COLS)
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    asynchronous reset, active-low
//  wr_en      in   1                    write request
//  wr_addr    in   WA_W                 word address in write bank
//  wr_data    in   LANES*DATA_W         lane k at [k*DATA_W +: DATA_W]
//  wr_last    in   1                    with accepted write: commit bank as FULL
//  wr_ready   out  1                    write bank not FULL
//  rd_en      in   1                    read request
//  rd_addr    in   RA_W                 base_row=rd_addr/COLS, col=rd_addr%COLS
//  rd_release in   1                    reader done with read bank
//  rd_data    out  RD_LANES*DATA_W      lane i = mem[i*RD_STRIDE+base_row][col]
//  rd_valid   out  1                    rd_data updated this cycle
//  rd_avail   out  1                    read bank FULL
//  err        out  1                    sticky: dropped write/read/release or bad address
// BEHAVIOUR
//  Reset (rst=0, async): all memory 0; both banks EMPTY; wr_ptr=rd_ptr=0; rd_data=0, rd_valid=0, err=0.
//  Per-bank FSM: EMPTY -(accepted write, wr_last=0)-> FILLING; EMPTY/FILLING -(accepted write, wr_last=1)-> FULL;
//   FULL -(rd_release)-> EMPTY. On FULL commit wr_ptr toggles; on release rd_ptr toggles.
//  wr_ready = (state[wr_ptr] != FULL), combinational from state only.
//  Accepted write: wr_en & wr_ready & wr_addr<WORDS; row=wr_addr/(COLS/LANES),
//   col0=(wr_addr%(COLS/LANES))*LANES; mem[row][col0+k] <= lane k. Write visible to reads next cycle.
//  wr_en & !wr_ready, or wr_addr>=WORDS: no memory change, no state change, err<=1.
//  rd_avail = (state[rd_ptr] == FULL). Accepted read: rd_en & rd_avail & rd_addr<RD_STRIDE*COLS;
//   next cycle rd_data <= column, rd_valid=1. rd_valid is a 1-cycle pulse; rd_data holds until next accepted read.
//  rd_en & !rd_avail or out-of-range rd_addr: rd_valid=0, rd_data holds, err<=1.
//  rd_release & !rd_avail: ignored, err<=1.
//  rd_en & rd_release same cycle: read samples current bank, then bank released (read wins ordering).
//  wr_last commit and rd_release same cycle: both take effect (different banks by construction).
//  Release does not clear bank contents; rewrite overwrites. Words not rewritten keep prior data.
//  Both banks FULL: wr_ready=0 until release. wr_last accepted on any address (partial fill allowed).
//  Reset mid-operation: immediate return to reset state; in-flight read produces no rd_valid.
//  err clears only on reset.
// STRUCTURE
//  Package cadm_buff_pkg: typedef enum logic[1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t;
//   functions for row/col address decode.
//  Sub-module buff_bank (one per bank, 2 instances): ROWSxCOLS storage, LANES-wide write port,
//   combinational RD_LANES strided column read; top holds FSMs, pointers, output regs, err.
// TESTING
//  T1 reset: rst=0 mid-write -> rd_data=0, rd_valid=0, wr_ready=1, rd_avail=0, err=0.
//  T2 fill bank0 addr 0..15 data {4k+3,4k+2,4k+1,4k} bytes, wr_last on 15 -> rd_avail=1 next cycle;
//   rd_addr=9 -> 1 cycle later rd_data lanes = {57,41,25,9}, rd_valid pulse.
//  T3 ping-pong: fill bank1 while reading bank0; commit bank1 -> wr_ready=0; extra write dropped, err=1;
//   rd_release -> wr_ready=1 next cycle, reads now return bank1 data.
//  T4 same cycle rd_en(addr 0)+rd_release -> rd_data from old bank, rd_avail reflects new bank.
//  T5 rd_en with rd_avail=0 -> rd_valid=0, rd_data unchanged, err=1; rd_release with rd_avail=0 -> no pointer change.
//  T6 params DATA_W=16,ROWS=4,COLS=8,LANES=2,RD_LANES=2,RD_STRIDE=2: repeat T2 against reference model.

Source files
------------

// File: rtl/cadm_buff_pkg.sv
// Shared types and address-decode helpers for the ping-pong convolution input buffer.
package cadm_buff_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  localparam int NUM_BANKS = 2;

  // Write word address -> storage row (words are laid out row-major).
  function automatic int word_row(input int addr, input int words_per_row);
    return addr / words_per_row;
  endfunction

  // Write word address -> first column covered by the word.
  function automatic int word_col0(input int addr, input int words_per_row, input int lanes);
    return (addr % words_per_row) * lanes;
  endfunction

  // Read address -> base row of the strided column.
  function automatic int rd_base_row(input int addr, input int cols);
    return addr / cols;
  endfunction

  // Read address -> column index.
  function automatic int rd_col(input int addr, input int cols);
    return addr % cols;
  endfunction

endpackage

// File: rtl/buff_bank.sv
// One storage bank: ROWS x COLS elements, LANES-wide row write, strided RD_LANES column read.
module buff_bank #(
  parameter int DATA_W    = 8,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int LANES     = 4,
  parameter int RD_LANES  = 4,
  parameter int RD_STRIDE = 2,
  parameter int RW        = $clog2(ROWS),
  parameter int CW        = $clog2(COLS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [RW-1:0]              wr_row,
  input  logic [CW-1:0]              wr_col0,
  input  logic [LANES*DATA_W-1:0]    wr_data,
  input  logic [RW-1:0]              rd_row,
  input  logic [CW-1:0]              rd_col,
  output logic [RD_LANES*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [ROWS][COLS];

  // Storage: cleared on reset, one word of LANES adjacent elements written per accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (we) begin
      for (int k = 0; k < LANES; k++) begin
        mem[wr_row][wr_col0 + CW'(k)] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Column read: lane gi comes from row gi*RD_STRIDE + rd_row; registering happens in the top.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LANES; gi++) begin : g_rd_lane
      assign rd_data[gi*DATA_W +: DATA_W] = mem[RW'(gi*RD_STRIDE) + rd_row][rd_col];
    end
  endgenerate

endmodule

// File: rtl/pingpong_main_buff.sv
// Double-banked convolution input buffer: loader fills one bank while the engine reads the other.
module pingpong_main_buff
  import cadm_buff_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int LANES     = 4,
  parameter int RD_LANES  = 4,
  parameter int RD_STRIDE = 2,
  localparam int WORDS    = ROWS * COLS / LANES,
  localparam int WA_W     = $clog2(WORDS),
  localparam int RA_W     = $clog2(RD_STRIDE * COLS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WA_W-1:0]            wr_addr,
  input  logic [LANES*DATA_W-1:0]    wr_data,
  input  logic                       wr_last,
  output logic                       wr_ready,
  input  logic                       rd_en,
  input  logic [RA_W-1:0]            rd_addr,
  input  logic                       rd_release,
  output logic [RD_LANES*DATA_W-1:0] rd_data,
  output logic                       rd_valid,
  output logic                       rd_avail,
  output logic                       err
);

  localparam int WPR   = COLS / LANES;
  localparam int RD_SP = RD_STRIDE * COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  generate
    if (RD_LANES * RD_STRIDE != ROWS) begin : g_bad_stride
      $error("pingpong_main_buff: RD_LANES*RD_STRIDE must equal ROWS");
    end
    if (COLS % LANES != 0) begin : g_bad_lanes
      $error("pingpong_main_buff: COLS must be a multiple of LANES");
    end
  endgenerate

  bank_state_t state_reg [NUM_BANKS];
  bank_state_t state_next [NUM_BANKS];
  logic        wr_ptr_reg, wr_ptr_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic [RD_LANES*DATA_W-1:0] rd_data_reg;
  logic        rd_valid_reg;
  logic        err_reg;

  logic wr_in_range, rd_in_range;
  logic wr_accept, rd_accept, rel_accept, err_set;
  logic [RW-1:0] wr_row, rd_row;
  logic [CW-1:0] wr_col0, rd_col_idx;
  logic [RD_LANES*DATA_W-1:0] bank_rd_data [NUM_BANKS];

  // Range checks only exist when the address field can exceed the storage.
  generate
    if ((2 ** WA_W) == WORDS) begin : g_wr_full_range
      assign wr_in_range = 1'b1;
    end else begin : g_wr_part_range
      assign wr_in_range = (wr_addr < WA_W'(WORDS));
    end
    if ((2 ** RA_W) == RD_SP) begin : g_rd_full_range
      assign rd_in_range = 1'b1;
    end else begin : g_rd_part_range
      assign rd_in_range = (rd_addr < RA_W'(RD_SP));
    end
  endgenerate

  assign wr_row     = RW'(word_row(32'(wr_addr), WPR));
  assign wr_col0    = CW'(word_col0(32'(wr_addr), WPR, LANES));
  assign rd_row     = RW'(rd_base_row(32'(rd_addr), COLS));
  assign rd_col_idx = CW'(rd_col(32'(rd_addr), COLS));

  assign wr_ready   = (state_reg[wr_ptr_reg] != BANK_FULL);
  assign rd_avail   = (state_reg[rd_ptr_reg] == BANK_FULL);
  assign wr_accept  = wr_en & wr_ready & wr_in_range;
  assign rd_accept  = rd_en & rd_avail & rd_in_range;
  assign rel_accept = rd_release & rd_avail;
  assign err_set    = (wr_en & ~(wr_ready & wr_in_range))
                    | (rd_en & ~(rd_avail & rd_in_range))
                    | (rd_release & ~rd_avail);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      buff_bank #(
        .DATA_W    (DATA_W),
        .ROWS      (ROWS),
        .COLS      (COLS),
        .LANES     (LANES),
        .RD_LANES  (RD_LANES),
        .RD_STRIDE (RD_STRIDE),
        .RW        (RW),
        .CW        (CW)
      ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_accept && (wr_ptr_reg == 1'(gi))),
        .wr_row  (wr_row),
        .wr_col0 (wr_col0),
        .wr_data (wr_data),
        .rd_row  (rd_row),
        .rd_col  (rd_col_idx),
        .rd_data (bank_rd_data[gi])
      );
    end
  endgenerate

  // Bank FSM and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_reg[b] <= BANK_EMPTY;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Next state: write and release always touch different banks, so both may apply at once.
  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_accept) begin
      state_next[wr_ptr_reg] = wr_last ? BANK_FULL : BANK_FILLING;
      if (wr_last) begin
        wr_ptr_next = ~wr_ptr_reg;
      end
    end
    if (rel_accept) begin
      state_next[rd_ptr_reg] = BANK_EMPTY;
      rd_ptr_next = ~rd_ptr_reg;
    end
  end

  // Registered read port and sticky error flag; the read samples the bank before any release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        rd_data_reg <= bank_rd_data[rd_ptr_reg];
      end
      if (err_set) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_pingpong_main_buff.sv
// Directed scoreboard bench for pingpong_main_buff (default and 16-bit parameter sets).
module tb_pingpong_main_buff;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_wr_en, a_wr_last, a_wr_ready, a_rd_en, a_rd_release, a_rd_valid, a_rd_avail, a_err;
  logic [3:0]  a_wr_addr, a_rd_addr;
  logic [31:0] a_wr_data, a_rd_data;

  // Instance B: DATA_W=16, ROWS=4, COLS=8, LANES=2, RD_LANES=2, RD_STRIDE=2
  logic        b_wr_en, b_wr_last, b_wr_ready, b_rd_en, b_rd_release, b_rd_valid, b_rd_avail, b_err;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data, b_rd_data;

  pingpong_main_buff dut_a (
    .clk(clk), .rst(rst),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_last(a_wr_last),
    .wr_ready(a_wr_ready), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_release(a_rd_release),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_avail(a_rd_avail), .err(a_err)
  );

  pingpong_main_buff #(
    .DATA_W(16), .ROWS(4), .COLS(8), .LANES(2), .RD_LANES(2), .RD_STRIDE(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_last(b_wr_last),
    .wr_ready(b_wr_ready), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_release(b_rd_release),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_avail(b_rd_avail), .err(b_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model for A: two banks of 8x8 bytes plus the expected bank pointers.
  logic [7:0]  ma [2][8][8];
  int          a_wbank, a_rbank;
  logic [31:0] sb_a [$];
  logic [31:0] a_last_exp;

  // Reference model for B: a single 4x8 bank of 16-bit elements.
  logic [15:0] mb [4][8];
  logic [31:0] sb_b [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_model_clear();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          ma[b][r][c] = 8'h00;
    a_wbank = 0;
    a_rbank = 0;
    a_last_exp = 32'h0;
    sb_a.delete();
  endtask

  function automatic logic [31:0] a_word(input int a, input int off);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(4*a + k + off);
    return w;
  endfunction

  function automatic logic [31:0] a_col(input int bank, input int addr);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = ma[bank][i*2 + addr/8][addr%8];
    return v;
  endfunction

  task automatic a_set_write(input int addr, input logic [31:0] data, input logic last, input bit acc);
    a_wr_en   = 1'b1;
    a_wr_addr = 4'(addr);
    a_wr_data = data;
    a_wr_last = last;
    if (acc) begin
      for (int k = 0; k < 4; k++) ma[a_wbank][addr/2][(addr%2)*4 + k] = data[k*8 +: 8];
      if (last) a_wbank ^= 1;
    end
  endtask

  task automatic a_set_read(input int addr);
    a_rd_en   = 1'b1;
    a_rd_addr = 4'(addr);
    sb_a.push_back(a_col(a_rbank, addr));
  endtask

  task automatic a_set_release();
    a_rd_release = 1'b1;
    a_rbank ^= 1;
  endtask

  // Advance one cycle, drop requests, check the valid pulse and pop the scoreboard on output.
  task automatic a_step(input bit exp_valid, input string tag);
    tick();
    a_wr_en = 1'b0; a_wr_last = 1'b0; a_rd_en = 1'b0; a_rd_release = 1'b0;
    chk({tag, "_valid"}, 64'(a_rd_valid), 64'(exp_valid));
    if (a_rd_valid === 1'b1) begin
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_sb observed=rd_valid expected=no_output", tag);
      end else begin
        a_last_exp = sb_a.pop_front();
        chk({tag, "_data"}, 64'(a_rd_data), 64'(a_last_exp));
      end
    end
  endtask

  initial begin
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_wr_last = 0; a_rd_en = 0; a_rd_addr = 0; a_rd_release = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_last = 0; b_rd_en = 0; b_rd_addr = 0; b_rd_release = 0;
    a_model_clear();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) mb[r][c] = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // T1: reset values, then reset in the middle of a write with a read in flight
    chk("t1_init_rd_data", 64'(a_rd_data), 64'h0);
    chk("t1_init_rd_valid", 64'(a_rd_valid), 64'h0);
    chk("t1_init_wr_ready", 64'(a_wr_ready), 64'h1);
    chk("t1_init_rd_avail", 64'(a_rd_avail), 64'h0);
    chk("t1_init_err", 64'(a_err), 64'h0);
    a_rd_en = 1'b1; a_rd_addr = 4'd0;
    a_step(1'b0, "t1_rd_empty");
    chk("t1_err_set", 64'(a_err), 64'h1);
    a_set_write(0, 32'hDEADBEEF, 1'b1, 1'b1);
    a_step(1'b0, "t1_wr");
    chk("t1_avail", 64'(a_rd_avail), 64'h1);
    a_set_read(0);
    a_step(1'b1, "t1_rd");
    a_set_write(1, 32'h12345678, 1'b0, 1'b0);
    a_rd_en = 1'b1; a_rd_addr = 4'd3;
    #3 rst = 1'b0;
    #1;
    chk("t1_rst_rd_data", 64'(a_rd_data), 64'h0);
    chk("t1_rst_rd_valid", 64'(a_rd_valid), 64'h0);
    chk("t1_rst_wr_ready", 64'(a_wr_ready), 64'h1);
    chk("t1_rst_rd_avail", 64'(a_rd_avail), 64'h0);
    chk("t1_rst_err", 64'(a_err), 64'h0);
    tick();
    chk("t1_rst_no_valid", 64'(a_rd_valid), 64'h0);
    a_wr_en = 0; a_wr_last = 0; a_rd_en = 0; a_rd_release = 0;
    rst = 1'b1;
    a_model_clear();

    // T2: fill bank0, commit on the last word, read the strided column at address 9
    for (int a = 0; a < 16; a++) begin
      a_set_write(a, a_word(a, 0), (a == 15), 1'b1);
      a_step(1'b0, "t2_wr");
      if (a == 14) chk("t2_avail_before", 64'(a_rd_avail), 64'h0);
    end
    chk("t2_avail", 64'(a_rd_avail), 64'h1);
    chk("t2_wr_ready", 64'(a_wr_ready), 64'h1);
    a_set_read(9);
    a_step(1'b1, "t2_rd");
    chk("t2_rd_const", 64'(a_rd_data), 64'h39291909);
    a_step(1'b0, "t2_pulse");
    chk("t2_hold", 64'(a_rd_data), 64'h39291909);

    // T3: fill bank1 while streaming reads from bank0; both banks full then drop a write
    for (int a = 0; a < 16; a++) begin
      a_set_write(a, a_word(a, 64), (a == 15), 1'b1);
      a_set_read(a);
      a_step(1'b1, "t3_rd");
    end
    chk("t3_ready_full", 64'(a_wr_ready), 64'h0);
    chk("t3_err_clean", 64'(a_err), 64'h0);
    a_set_write(0, 32'hFFFFFFFF, 1'b0, 1'b0);
    a_step(1'b0, "t3_drop");
    chk("t3_err_drop", 64'(a_err), 64'h1);
    chk("t3_ready_still", 64'(a_wr_ready), 64'h0);
    a_set_release();
    a_step(1'b0, "t3_rel");
    chk("t3_ready_rel", 64'(a_wr_ready), 64'h1);
    chk("t3_avail_b1", 64'(a_rd_avail), 64'h1);
    a_set_read(0);
    a_step(1'b1, "t3_rd_b1");
    chk("t3_rd_b1_const", 64'(a_rd_data), 64'h70605040);

    // T4: read and release in the same cycle
    a_set_read(0);
    a_set_release();
    a_step(1'b1, "t4_rd");
    chk("t4_avail", 64'(a_rd_avail), 64'h0);
    chk("t4_wr_ready", 64'(a_wr_ready), 64'h1);

    // T5: partial fill, then read/release while nothing is available
    rst = 1'b0;
    #2 rst = 1'b1;
    a_model_clear();
    chk("t5_err_clear", 64'(a_err), 64'h0);
    a_set_write(3, a_word(3, 16), 1'b1, 1'b1);
    a_step(1'b0, "t5_wr");
    chk("t5_avail", 64'(a_rd_avail), 64'h1);
    a_set_read(12);
    a_step(1'b1, "t5_rd");
    a_set_release();
    a_step(1'b0, "t5_rel");
    chk("t5_avail_gone", 64'(a_rd_avail), 64'h0);
    a_rd_en = 1'b1; a_rd_addr = 4'd12;
    a_step(1'b0, "t5_rd_na");
    chk("t5_hold", 64'(a_rd_data), 64'(a_last_exp));
    chk("t5_err_rd", 64'(a_err), 64'h1);
    a_rd_release = 1'b1;
    a_step(1'b0, "t5_rel_na");
    a_set_write(0, a_word(0, 32), 1'b1, 1'b1);
    a_step(1'b0, "t5_wr_b1");
    chk("t5_ptr_kept", 64'(a_rd_avail), 64'h1);
    a_set_read(0);
    a_step(1'b1, "t5_rd_b1");

    // T6: 16-bit parameter set, fill then read every column against the model
    for (int a = 0; a < 16; a++) begin
      b_wr_en = 1'b1; b_wr_addr = 4'(a); b_wr_last = (a == 15);
      for (int k = 0; k < 2; k++) begin
        b_wr_data[k*16 +: 16] = 16'(16'h1000 + 2*a + k);
        mb[a/4][(a%4)*2 + k] = 16'(16'h1000 + 2*a + k);
      end
      tick();
      b_wr_en = 1'b0; b_wr_last = 1'b0;
    end
    chk("t6_avail", 64'(b_rd_avail), 64'h1);
    for (int ad = 0; ad < 16; ad++) begin
      logic [31:0] e;
      for (int i = 0; i < 2; i++) e[i*16 +: 16] = mb[i*2 + ad/8][ad%8];
      b_rd_en = 1'b1; b_rd_addr = 4'(ad);
      sb_b.push_back(e);
      tick();
      b_rd_en = 1'b0;
      chk("t6_valid", 64'(b_rd_valid), 64'h1);
      if (b_rd_valid === 1'b1 && sb_b.size() > 0) chk("t6_data", 64'(b_rd_data), 64'(sb_b.pop_front()));
      if (ad == 9) chk("t6_rd_const", 64'(b_rd_data), 64'h10191009);
    end
    chk("t6_err", 64'(b_err), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
